// File: rtl/npu_stream_dispatcher.sv
// npu_stream_dispatcher
//   Host-side AXI-Stream front end for the NPU. Each packet is a 32-bit command
//   header (HDR_BEATS little-endian beats) followed by optional payload beats.
//   Valid headers are queued in a command FIFO for the instruction decoder.
//   Payload is passed through combinationally to the channel named in hdr[23:16].
//   Runt headers and headers naming a missing channel are counted as errors,
//   dropped, and raise a sticky interrupt.
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready/tlast  host stream (DATA_W wide)
//   cmd_data/cmd_valid/cmd_ready   command FIFO head towards the decoder
//   ch_tdata/tvalid/tready/tlast   NUM_CH payload streams, lane i at [i*DATA_W +: DATA_W]
//   irq_clear, interrupt           interrupt clear pulse and sticky error interrupt
//   status                         {7'b0, irq, level[3:0], drop, payload, empty, full, err_cnt, pkt_cnt}
module npu_stream_dispatcher #(
  parameter int DATA_W         = 16,
  parameter int NUM_CH         = 4,
  parameter int CMD_FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [31:0]              cmd_data,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [NUM_CH*DATA_W-1:0] ch_tdata,
  output logic [NUM_CH-1:0]        ch_tvalid,
  input  logic [NUM_CH-1:0]        ch_tready,
  output logic [NUM_CH-1:0]        ch_tlast,
  input  logic                     irq_clear,
  output logic                     interrupt,
  output logic [31:0]              status
);

  localparam int HDR_BEATS = 32 / DATA_W;
  localparam int BC_W      = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W     = $clog2(CMD_FIFO_DEPTH);
  localparam int LVL_W     = PTR_W + 1;
  localparam logic [8:0] NUM_CH_L = 9'(NUM_CH);

  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

  state_t            state_q, state_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic [31:0]       hdr_q, hdr_d, hdr_full;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [7:0]        pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic              irq_q, irq_d;
  logic [31:0]       status_q, status_d;
  logic [31:0]       mem_q [CMD_FIFO_DEPTH];

  logic fifo_full, fifo_empty, push, pop, err, last_hdr_beat, hs;
  logic [7:0] hdr_ch;

  assign fifo_full  = (level_q == LVL_W'(CMD_FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign cmd_valid  = !fifo_empty;
  assign cmd_data   = mem_q[rd_ptr_q];
  assign pop        = cmd_valid && cmd_ready;
  assign interrupt  = irq_q;
  assign status     = status_q;
  assign last_hdr_beat = (beat_cnt_q == BC_W'(HDR_BEATS - 1));
  assign hs         = s_axis_tvalid && s_axis_tready;
  assign hdr_ch     = hdr_full[23:16];

  // Header as it would look with the current beat merged in.
  always_comb begin
    hdr_full = hdr_q;
    for (int k = 0; k < HDR_BEATS; k++) begin
      if (beat_cnt_q == BC_W'(k)) hdr_full[k*DATA_W +: DATA_W] = s_axis_tdata;
    end
  end

  // Payload lanes: every lane sees the data; only the selected one is valid.
  always_comb begin
    ch_tdata  = {NUM_CH{s_axis_tdata}};
    ch_tvalid = '0;
    ch_tlast  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q == PAYLOAD && sel_q == CH_W'(i)) begin
        ch_tvalid[i] = s_axis_tvalid;
        ch_tlast[i]  = s_axis_tlast;
      end
    end
  end

  // Next state, ready and header/FIFO control
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    sel_d         = sel_q;
    hdr_d         = hdr_q;
    push          = 1'b0;
    err           = 1'b0;
    s_axis_tready = 1'b1;
    case (state_q)
      HDR: begin
        // Stall only the final header beat so a full FIFO never loses a push.
        if (last_hdr_beat) s_axis_tready = !fifo_full;
        if (hs) begin
          if (!last_hdr_beat) begin
            if (s_axis_tlast) begin
              err        = 1'b1;
              beat_cnt_d = '0;
            end else begin
              hdr_d      = hdr_full;
              beat_cnt_d = beat_cnt_q + BC_W'(1);
            end
          end else begin
            beat_cnt_d = '0;
            if ({1'b0, hdr_ch} >= NUM_CH_L) begin
              err = 1'b1;
              if (!s_axis_tlast) state_d = DROP;
            end else begin
              push = 1'b1;
              if (!s_axis_tlast) begin
                sel_d   = hdr_ch[CH_W-1:0];
                state_d = PAYLOAD;
              end
            end
          end
        end
      end
      PAYLOAD: begin
        s_axis_tready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (sel_q == CH_W'(i)) s_axis_tready = ch_tready[i];
        end
        if (hs && s_axis_tlast) state_d = HDR;
      end
      DROP: begin
        if (hs && s_axis_tlast) state_d = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  // FIFO pointers, counters, interrupt and registered status
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
    pkt_cnt_d = pkt_cnt_q + 8'(push);
    err_cnt_d = (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    // A new error wins over a simultaneous clear.
    irq_d     = err ? 1'b1 : (irq_clear ? 1'b0 : irq_q);
    status_d  = {7'd0, irq_d, 4'(level_d), state_d == DROP, state_d == PAYLOAD,
                 level_d == '0, level_d == LVL_W'(CMD_FIFO_DEPTH), err_cnt_d, pkt_cnt_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HDR;
      beat_cnt_q <= '0;
      sel_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      irq_q      <= 1'b0;
      status_q   <= 32'h0002_0000;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      sel_q      <= sel_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      irq_q      <= irq_d;
      status_q   <= status_d;
    end
  end

  // Datapath storage carries no reset; it is only read once qualified by control.
  always_ff @(posedge clk) begin
    hdr_q <= hdr_d;
    if (push) mem_q[wr_ptr_q] <= hdr_full;
  end

endmodule

// File: tb/tb_npu_stream_dispatcher.sv
module tb_npu_stream_dispatcher;
  localparam int DATA_W = 16;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [DATA_W-1:0]        s_axis_tdata;
  logic                     s_axis_tvalid;
  logic                     s_axis_tready;
  logic                     s_axis_tlast;
  logic [31:0]              cmd_data;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [NUM_CH*DATA_W-1:0] ch_tdata;
  logic [NUM_CH-1:0]        ch_tvalid;
  logic [NUM_CH-1:0]        ch_tready;
  logic [NUM_CH-1:0]        ch_tlast;
  logic                     irq_clear;
  logic                     interrupt;
  logic [31:0]              status;

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;
  logic [DATA_W-1:0] rx_q[$];
  logic [DATA_W-1:0] beats [4];

  npu_stream_dispatcher #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CMD_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .ch_tdata(ch_tdata), .ch_tvalid(ch_tvalid), .ch_tready(ch_tready), .ch_tlast(ch_tlast),
    .irq_clear(irq_clear), .interrupt(interrupt), .status(status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mon_en && ch_tvalid[1] && ch_tready[1]) rx_q.push_back(ch_tdata[DATA_W +: DATA_W]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
    int n;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (!s_axis_tready && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) chk("beat_timeout", 32'd1, 32'd0);
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic pop_one();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  task automatic pulse_irq_clear();
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    cmd_ready = 1'b0; ch_tready = 4'hF; irq_clear = 1'b0;
    beats[0] = 16'hD000; beats[1] = 16'hD001; beats[2] = 16'hD002; beats[3] = 16'hD003;
    tick(); tick();
    chk("rst_tready", 32'(s_axis_tready), 32'd1);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_ch_tvalid", 32'(ch_tvalid), 32'd0);
    chk("rst_ch_tlast", 32'(ch_tlast), 32'd0);
    chk("rst_irq", 32'(interrupt), 32'd0);
    chk("rst_status", status, 32'h0002_0000);
    @(negedge clk); rst_n = 1'b1;

    // T1: header ch=2 plus two payload beats
    send_beat(16'h0001, 1'b0);
    send_beat(16'h0002, 1'b0);
    chk("t1_cmd_valid", 32'(cmd_valid), 32'd1);
    chk("t1_cmd_data", cmd_data, 32'h0002_0001);
    chk("t1_status_payload", status, 32'h0014_0001);
    s_axis_tdata = 16'hAAAA; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1; #1;
    chk("t1_ch_tvalid0", 32'(ch_tvalid), 32'h4);
    chk("t1_ch2_data0", 32'(ch_tdata[2*DATA_W +: DATA_W]), 32'hAAAA);
    chk("t1_ch_tlast0", 32'(ch_tlast), 32'h0);
    chk("t1_tready", 32'(s_axis_tready), 32'd1);
    tick();
    s_axis_tdata = 16'hBBBB; s_axis_tlast = 1'b1; #1;
    chk("t1_ch2_data1", 32'(ch_tdata[2*DATA_W +: DATA_W]), 32'hBBBB);
    chk("t1_ch_tlast1", 32'(ch_tlast), 32'h4);
    tick();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    chk("t1_status_end", status, 32'h0010_0001);
    pop_one();
    chk("t1_popped", 32'(cmd_valid), 32'd0);

    // T2: bad channel -> drop three payload beats
    send_beat(16'h0000, 1'b0);
    send_beat(16'h0005, 1'b0);
    chk("t2_irq", 32'(interrupt), 32'd1);
    chk("t2_no_push", 32'(cmd_valid), 32'd0);
    chk("t2_status_drop", status, 32'h010A_0101);
    s_axis_tvalid = 1'b1; #1;
    chk("t2_drop_ch_tvalid", 32'(ch_tvalid), 32'd0);
    chk("t2_drop_tready", 32'(s_axis_tready), 32'd1);
    send_beat(16'h1111, 1'b0);
    send_beat(16'h2222, 1'b0);
    send_beat(16'h3333, 1'b1);
    chk("t2_status_after", status, 32'h0102_0101);
    pulse_irq_clear();
    chk("t2_irq_cleared", 32'(interrupt), 32'd0);
    chk("t2_status_cleared", status, 32'h0002_0101);

    // T3: runt packet, then a good command-only packet
    send_beat(16'h1234, 1'b1);
    chk("t3_status_runt", status, 32'h0102_0201);
    chk("t3_fifo_untouched", 32'(cmd_valid), 32'd0);
    pulse_irq_clear();
    send_beat(16'h5678, 1'b0);
    send_beat(16'h0003, 1'b1);
    chk("t3_cmd_data", cmd_data, 32'h0003_5678);
    chk("t3_status_good", status, 32'h0010_0202);
    pop_one();

    // T4: fill the FIFO, fifth final beat must stall until a pop
    for (int i = 0; i < 4; i++) begin
      send_beat(16'h1000 + 16'(i), 1'b0);
      send_beat(16'h0000, 1'b1);
    end
    chk("t4_status_full", status, 32'h0041_0206);
    send_beat(16'h1004, 1'b0);
    s_axis_tdata = 16'h0000; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1; #1;
    chk("t4_stall0", 32'(s_axis_tready), 32'd0);
    tick();
    chk("t4_stall1", 32'(s_axis_tready), 32'd0);
    chk("t4_head0", cmd_data, 32'h0000_1000);
    pop_one();
    chk("t4_ready_after_pop", 32'(s_axis_tready), 32'd1);
    tick();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    chk("t4_pkt_cnt", 32'(status[7:0]), 32'd7);
    for (int i = 1; i < 5; i++) begin
      chk("t4_order", cmd_data, 32'h0000_1000 + 32'(i));
      pop_one();
    end
    chk("t4_drained", 32'(cmd_valid), 32'd0);

    // T5: ch1 payload with ch_tready[1] toggling
    send_beat(16'h0000, 1'b0);
    send_beat(16'h0001, 1'b0);
    pop_one();
    mon_en = 1'b1;
    begin
      int idx, n;
      logic tog;
      idx = 0; n = 0; tog = 1'b0;
      while (idx < 4 && n < 50) begin
        s_axis_tdata = beats[idx]; s_axis_tlast = (idx == 3); s_axis_tvalid = 1'b1;
        ch_tready[1] = tog;
        #1;
        chk("t5_mirror", 32'(s_axis_tready), 32'(tog));
        tick();
        if (tog) idx++;
        tog = !tog;
        n++;
      end
      if (n == 50) chk("t5_timeout", 32'd1, 32'd0);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; ch_tready = 4'hF;
    mon_en = 1'b0;
    chk("t5_rx_count", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) chk("t5_rx_data", 32'(rx_q[i]), 32'(beats[i]));
    chk("t5_back_in_hdr", status, 32'h0002_0208);

    // T6: asynchronous reset mid-payload
    send_beat(16'h0000, 1'b0);
    send_beat(16'h0002, 1'b0);
    s_axis_tdata = 16'hCCCC; s_axis_tvalid = 1'b1; #1;
    chk("t6_pre_rst_tvalid", 32'(ch_tvalid), 32'h4);
    #2 rst_n = 1'b0; #1;
    chk("t6_rst_ch_tvalid", 32'(ch_tvalid), 32'd0);
    chk("t6_rst_ch_tlast", 32'(ch_tlast), 32'd0);
    chk("t6_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("t6_rst_tready", 32'(s_axis_tready), 32'd1);
    chk("t6_rst_status", status, 32'h0002_0000);
    s_axis_tvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    send_beat(16'hBEEF, 1'b0);
    send_beat(16'h0001, 1'b1);
    chk("t6_new_cmd", cmd_data, 32'h0001_BEEF);
    chk("t6_new_status", status, 32'h0010_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
